// File: rtl/cla_mw_add_ctrl.sv
// Multi-word add/subtract sequencer: one 32-bit carry-lookahead slice per cycle,
// least-significant word first, with carry, signed-overflow and zero flags.

module cla_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        pm,
  output logic        gm
);
  logic [31:0] p, g, c;
  logic        gg, gp, gpre, ppre, cg;

  // 4-bit lookahead groups; pm/gm summarise the whole slice without cin
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    pm   = 1'b1;
    gm   = 1'b0;
    gg   = 1'b0;
    gp   = 1'b1;
    gpre = 1'b0;
    ppre = 1'b1;
    cg   = cin;
    for (int j = 0; j < 8; j++) begin
      cg   = (j == 0) ? cin : (gm | (pm & cin));
      gpre = 1'b0;
      ppre = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gpre = g[4*j+i] | (p[4*j+i] & gpre);
        ppre = ppre & p[4*j+i];
        if (4*j+i < 31) c[4*j+i+1] = gpre | (ppre & cg);
      end
      gg = gpre;
      gp = ppre;
      gm = gg | (gp & gm);
      pm = pm & gp;
    end
    s = p ^ c;
  end
endmodule

module cla_mw_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                op_sub,
  input  logic [32*WORDS-1:0] a,
  input  logic [32*WORDS-1:0] b,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [32*WORDS-1:0] res,
  output logic                cout,
  output logic                ovf,
  output logic                zero,
  output logic                busy
);
  localparam int N  = 32 * WORDS;
  localparam int KW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            c_q, c_d;
  logic [N-1:0]    res_q, res_d;
  logic            cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [N-1:0]    a_q, b_q;
  logic            load;

  logic [31:0]     a_w, b_w, s_w;
  logic            pm_w, gm_w, c_next;

  assign a_w    = a_q[32*k_q +: 32];
  assign b_w    = b_q[32*k_q +: 32];
  assign c_next = gm_w | (pm_w & c_q);

  cla_32bits u_cla (
    .a   (a_w),
    .b   (b_w),
    .cin (c_q),
    .s   (s_w),
    .pm  (pm_w),
    .gm  (gm_w)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = RUN;
          k_d     = '0;
          c_d     = op_sub;
          res_d   = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        res_d[32*k_q +: 32] = s_w;
        c_d                 = c_next;
        if (k_q == KW'(WORDS-1)) begin
          // counter parks on the last word instead of wrapping
          state_d = DONE;
          cout_d  = c_next;
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (s_w[31] != a_q[N-1]);
          zero_d  = (res_q == '0) && (s_w == '0);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // operand registers carry no reset; they are only read in RUN after a load
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a;
      b_q <= op_sub ? ~b : b;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done_valid  = (state_q == DONE);
  assign res         = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;
endmodule

// File: tb/tb_cla_mw_add_ctrl.sv
// Directed bench for cla_mw_add_ctrl with WORDS = 4 (128-bit operands).

module tb_cla_mw_add_ctrl;
  logic         clk = 1'b0;
  logic         rst, start_valid, start_ready, op_sub;
  logic [127:0] a, b, res;
  logic         done_valid, done_ready, cout, ovf, zero, busy;
  int           checks = 0;
  int           errors = 0;
  logic [127:0] ones, smax, smin, held;

  always #5 clk = ~clk;

  cla_mw_add_ctrl #(.WORDS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .a           (a),
    .b           (b),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .res         (res),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept, count edges to done_valid, check result/flags, then consume
  task automatic run_op(input string tag, input logic [127:0] av, input logic [127:0] bv,
                        input logic sub, input logic [127:0] er, input logic ec,
                        input logic eo, input logic ez);
    int n;
    a = av; b = bv; op_sub = sub; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = '0; b = '0; op_sub = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (n == 0) begin
        step();
        if (done_valid) n = i;
      end
    end
    chk({tag, "_latency"}, 128'(n), 128'(4));
    chk({tag, "_res"}, res, er);
    chk({tag, "_cout"}, 128'(cout), 128'(ec));
    chk({tag, "_ovf"}, 128'(ovf), 128'(eo));
    chk({tag, "_zero"}, 128'(zero), 128'(ez));
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk({tag, "_idle"}, 128'(start_ready), 128'(1));
  endtask

  initial begin
    ones = '1;
    smax = {1'b0, {127{1'b1}}};
    smin = {1'b1, {127{1'b0}}};
    rst = 1'b1; start_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; done_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_start_ready", 128'(start_ready), 128'(1));
    chk("rst_done_valid", 128'(done_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_res", res, 128'(0));
    chk("rst_flags", {125'(0), cout, ovf, zero}, 128'(0));

    run_op("carry_chain", ones, 128'(1), 1'b0, 128'(0), 1'b1, 1'b0, 1'b1);
    run_op("sub_borrow", 128'(0), 128'(1), 1'b1, ones, 1'b0, 1'b0, 1'b0);
    run_op("ovf_add", smax, 128'(1), 1'b0, smin, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub", smin, 128'(1), 1'b1, smax, 1'b1, 1'b1, 1'b0);
    run_op("isolation", 128'h00000000_FFFFFFFF_00000000_FFFFFFFF, 128'(1), 1'b0,
           128'h00000000_FFFFFFFF_00000001_00000000, 1'b0, 1'b0, 1'b0);
    run_op("sub_equal", 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
           128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b1, 128'(0), 1'b1, 1'b0, 1'b1);
    run_op("mixed_add", 128'h00000001_80000000_7FFFFFFF_FFFFFFFF,
           128'h00000002_80000000_00000000_00000001, 1'b0,
           128'h00000004_00000000_80000000_00000000, 1'b0, 1'b0, 1'b0);

    // backpressure: result held while a new request waits
    a = 128'(5); b = 128'(3); op_sub = 1'b0; start_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      a = 128'(100 + i); b = 128'(200 + i);
      step();
    end
    chk("bp_done_rise", 128'(done_valid), 128'(1));
    held = res;
    chk("bp_res", held, 128'(8));
    for (int i = 0; i < 5; i++) begin
      a = 128'(300 + i); b = 128'(400 + i); op_sub = i[0];
      step();
      chk("bp_hold_valid", 128'(done_valid), 128'(1));
      chk("bp_hold_ready", 128'(start_ready), 128'(0));
      chk("bp_hold_res", {res[124:0], cout, ovf, zero}, {128'(8) << 3});
    end
    op_sub = 1'b0; done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk("bp_back_idle", 128'(start_ready), 128'(1));
    a = 128'(7); b = 128'(9);
    step();
    start_valid = 1'b0; a = 128'(1000); b = 128'(1000);
    chk("bp_accept_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 4; i++) step();
    chk("bp_new_valid", 128'(done_valid), 128'(1));
    chk("bp_new_res", res, 128'(16));
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;

    // reset while the third word is being processed
    a = 128'(1000); b = 128'(1); start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 128'(start_ready), 128'(1));
    chk("mid_rst_valid", 128'(done_valid), 128'(0));
    chk("mid_rst_res", res, 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 6; i++) step();
    chk("mid_rst_no_done", 128'(done_valid), 128'(0));
    run_op("after_rst", 128'(1), 128'(1), 1'b0, 128'(2), 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
